// File: rtl/blind_pixel_table_ctrl.sv
// Double-banked blind-pixel table: host fills staging, a scan validates it,
// and the banks swap at the next end-of-frame.
module blind_pixel_table_ctrl #(
  parameter int MAX_PIXELS = 327680
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  cfg_address,
  input  logic        cfg_write,
  input  logic [31:0] cfg_writedata,
  input  logic        cfg_read,
  output logic [31:0] cfg_readdata,
  output logic        cfg_readdatavalid,
  input  logic        ram_read,
  input  logic [7:0]  ram_address,
  output logic [31:0] ram_readdata,
  input  logic        din_valid,
  input  logic        din_endofpacket,
  output logic        active_bank
);

  typedef enum logic [1:0] {IDLE, SCAN, PEND} state_t;
  localparam logic [31:0] MAX_W = 32'(MAX_PIXELS);

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic [1:0]  committed_q, committed_d;
  logic        scan_err_q, scan_err_d;
  logic        wr_drop_q, wr_drop_d;
  logic [31:0] swap_cnt_q, swap_cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  n_q, n_d;
  logic [31:0] prev_q, prev_d;
  logic [31:0] cfg_rdata_q, cfg_rdata_d;
  logic        cfg_rdv_q, cfg_rdv_d;
  logic [31:0] ram_rdata_q, ram_rdata_d;
  logic [31:0] mem_q [512];

  logic        stg_bank, stg_wr, ctrl_wr, stat_wr;
  logic        commit, eop, mem_we;
  logic [31:0] scan_word, stg_word;
  logic        scan_bad, scan_done;

  assign stg_bank  = ~active_q;
  assign stg_wr    = cfg_write & ~cfg_address[8];
  assign ctrl_wr   = cfg_write & cfg_address[8] &
                     (cfg_address[7:0] == 8'h00);
  assign stat_wr   = cfg_write & cfg_address[8] &
                     (cfg_address[7:0] == 8'h01);
  assign commit    = ctrl_wr & cfg_writedata[0];
  assign eop       = din_valid & din_endofpacket;
  assign scan_word = mem_q[{stg_bank, idx_q}];
  assign stg_word  = mem_q[{stg_bank, cfg_address[7:0]}];

  // Word 0 carries N; entries must stay in range and strictly ascend.
  assign scan_bad  = (idx_q != 8'd0) &&
                     ((scan_word >= MAX_W) ||
                      ((idx_q > 8'd1) && (scan_word <= prev_q)));
  assign scan_done = (idx_q == 8'd0) ? (scan_word[7:0] == 8'd0)
                                     : (idx_q == n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      committed_q <= 2'b00;
      scan_err_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
      swap_cnt_q  <= 32'd0;
      idx_q       <= 8'd0;
      n_q         <= 8'd0;
      prev_q      <= 32'd0;
      cfg_rdata_q <= 32'd0;
      cfg_rdv_q   <= 1'b0;
      ram_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      committed_q <= committed_d;
      scan_err_q  <= scan_err_d;
      wr_drop_q   <= wr_drop_d;
      swap_cnt_q  <= swap_cnt_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      prev_q      <= prev_d;
      cfg_rdata_q <= cfg_rdata_d;
      cfg_rdv_q   <= cfg_rdv_d;
      ram_rdata_q <= ram_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[{stg_bank, cfg_address[7:0]}] <= cfg_writedata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (commit) state_d = SCAN;
      SCAN: begin
        if (scan_bad)       state_d = IDLE;
        else if (scan_done) state_d = PEND;
      end
      PEND: if (eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active_d    = active_q;
    committed_d = committed_q;
    swap_cnt_d  = swap_cnt_q;
    idx_d       = idx_q;
    n_d         = n_q;
    prev_d      = prev_q;
    mem_we      = 1'b0;
    scan_err_d  = scan_err_q;
    wr_drop_d   = wr_drop_q;
    if (stat_wr) begin
      scan_err_d = scan_err_q & ~cfg_writedata[2];
      wr_drop_d  = wr_drop_q & ~cfg_writedata[3];
    end
    case (state_q)
      IDLE: begin
        mem_we = stg_wr;
        if (commit) idx_d = 8'd0;
      end
      SCAN: begin
        idx_d  = idx_q + 8'd1;
        prev_d = scan_word;
        if (idx_q == 8'd0) n_d = scan_word[7:0];
        if (scan_bad) scan_err_d = 1'b1;
      end
      PEND: begin
        if (eop) begin
          active_d              = stg_bank;
          committed_d[stg_bank] = 1'b1;
          swap_cnt_d            = swap_cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
    if (stg_wr && state_q != IDLE) wr_drop_d = 1'b1;

    cfg_rdv_d   = cfg_read;
    cfg_rdata_d = cfg_rdata_q;
    if (cfg_read) begin
      cfg_rdata_d = 32'd0;
      if (!cfg_address[8]) begin
        if (state_q != SCAN) cfg_rdata_d = stg_word;
      end else begin
        case (cfg_address[7:0])
          8'h01: cfg_rdata_d = {27'd0, active_q, wr_drop_q, scan_err_q,
                                state_q == PEND, state_q == SCAN};
          8'h02: cfg_rdata_d = swap_cnt_q;
          default: cfg_rdata_d = 32'd0;
        endcase
      end
    end

    ram_rdata_d = ram_rdata_q;
    if (ram_read)
      ram_rdata_d = committed_q[active_q] ?
                    mem_q[{active_q, ram_address}] : 32'd0;
  end

  assign cfg_readdata      = cfg_rdata_q;
  assign cfg_readdatavalid = cfg_rdv_q;
  assign ram_readdata      = ram_rdata_q;
  assign active_bank       = active_q;

endmodule

// File: doc/blind_pixel_table_ctrl.md
BLIND_PIXEL_TABLE_CTRL -- requirements
Module: blind_pixel_table_ctrl

Interface
REQ-001 SHALL have parameter MAX_PIXELS, default 327680, meaning pixels per frame; table entries at or above it are illegal.
REQ-002 SHALL have ports: clk input 1 (sole clock); rst input 1 (synchronous, active-high reset).
REQ-003 SHALL have ports: cfg_address input 9; cfg_write input 1; cfg_writedata input 32; cfg_read input 1; cfg_readdata output 32; cfg_readdatavalid output 1 (host slave).
REQ-004 SHALL have ports: ram_read input 1; ram_address input 8; ram_readdata output 32 (table port served to the blind-pixel processor).
REQ-005 SHALL have ports: din_valid input 1; din_endofpacket input 1 (video stream monitor, no handshake driven).
REQ-006 SHALL have port: active_bank output 1 (bank currently served on the ram_* port).

Function
REQ-007 SHALL hold two table banks, 256x32 each; word 0 = entry count N (bits 7:0), words 1..N = linear pixel indices; one bank active, the other staging.
REQ-008 SHALL serve ram_read from the active bank with 1-cycle latency: ram_read at cycle t -> ram_readdata valid at t+1, held until the next ram_read.
REQ-009 SHALL return 0 on ram_readdata when the active bank has never been committed since reset (processor then sees N=0).
REQ-010 SHALL map cfg_address[8]=0 to staging-bank word cfg_address[7:0]; [8]=1 to registers: 0x100 CTRL, 0x101 STATUS, 0x102 SWAP_CNT.
REQ-011 SHALL answer every cfg_read with cfg_readdatavalid exactly one cycle later; unmapped addresses read 0.
REQ-012 SHALL run a controller FSM with states IDLE, SCAN, PEND.
REQ-013 IDLE: staging writes accepted; write CTRL bit0=1 (commit) -> SCAN next cycle.
REQ-014 SCAN: read staging words 0..N one per cycle; fail if any index >= MAX_PIXELS or index k <= index k-1 (strictly ascending); N=0 passes trivially.
REQ-015 SCAN outcome: pass -> PEND; fail -> IDLE with STATUS.scan_err set; verdict no later than N+3 cycles after the commit write.
REQ-016 PEND: when din_valid & din_endofpacket at cycle t, active/staging banks swap effective t+1, new active bank marked committed, SWAP_CNT increments (32-bit, wraps), FSM -> IDLE.
REQ-017 ram_read at cycle t (eop cycle) SHALL read the old bank; ram_read at t+1 SHALL read the new bank.
REQ-018 After a swap, staging holds the previously active table; host SHALL rewrite it fully before the next commit.
REQ-019 Staging-table writes in SCAN or PEND SHALL be discarded and set STATUS.wr_drop.
REQ-020 Commit writes in SCAN or PEND SHALL be ignored (no restart, no flag).
REQ-021 Host staging-table reads during SCAN SHALL return 0 (scan owns the read port); other states return stored data.
REQ-022 STATUS SHALL read: bit0 scan busy, bit1 pending, bit2 scan_err, bit3 wr_drop, bit4 active_bank; bits 2,3 write-1-to-clear; others read 0.
REQ-023 Simultaneous clear-write and new set event on the same bit SHALL leave the bit set.
REQ-024 SWAP_CNT SHALL be read-only; writes ignored.

Reset
REQ-025 rst high at a clk edge SHALL force: FSM IDLE, active_bank 0, both banks uncommitted, STATUS 0, SWAP_CNT 0, cfg_readdatavalid 0, cfg_readdata 0, ram_readdata 0.
REQ-026 Reset mid-SCAN or mid-PEND SHALL abort with no swap; RAM contents are not cleared.

Verification
REQ-027 After reset, ram_read addr 0 -> ram_readdata 0 next cycle; STATUS reads 0x00.
REQ-028 Write N=3, entries 10,20,30, commit; pulse eop -> STATUS.pending until eop, active_bank 1 at eop+1, ram addr 0/1/3 return 3/10/30, SWAP_CNT 1.
REQ-029 Entries 10,10 (N=2) commit -> scan_err=1, FSM IDLE, no swap on eop; W1C STATUS 0x4 clears it.
REQ-030 Entry 327680 with default MAX_PIXELS -> scan_err=1, no swap.
REQ-031 In PEND, write staging word 5 -> write discarded, wr_drop=1; readback after swap shows old-active data at word 5.
REQ-032 ram_read addr 1 on eop cycle and eop+1 after valid commit -> old entry then new entry; rst asserted in PEND -> active_bank stays 0, SWAP_CNT 0.
